relu_act_pipe: RTL and testbench
================================

Name: relu_act_pipe

Overview:
Parametrised multi-channel activation stage placed between a conv/accumulate layer and the next layer's pooling or line buffer. Applies a run-time selectable activation (bypass, ReLU, leaky ReLU, clipped ReLU) to all channels of one pixel per beat. Provides one registered pipeline stage with full valid/ready back-pressure, and frame tracking (last-pixel flag, frame-done pulse) over an IMAGE_WIDTH x IMAGE_HEIGHT feature map.

Parameters:
CHANNELS, 64, channels processed in parallel per beat
DATA_BITS, 32, width of each signed two's-complement channel value
IMAGE_WIDTH, 13, feature-map width in pixels
IMAGE_HEIGHT, 17, feature-map height in pixels
LEAK_SHIFT, 3, leaky-ReLU negative slope = 2^-LEAK_SHIFT (arithmetic right shift)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
mode  in  2  00 bypass, 01 ReLU, 10 leaky ReLU, 11 clipped ReLU
clip_max  in  DATA_BITS  upper clamp for mode 11, treated as signed
valid_in  in  1  upstream beat valid
ready_out  out  1  this block can accept a beat
data_in  in  DATA_BITS x [0:CHANNELS-1]  signed input per channel
valid_out  out  1  output beat valid
ready_in  in  1  downstream can accept
data_out  out  DATA_BITS x [0:CHANNELS-1]  activated output per channel
last_out  out  1  qualifies the beat holding the final pixel of a frame
frame_done  out  1  one-cycle pulse when the final pixel of a frame is transferred out
zero_cnt  out  $clog2(CHANNELS*IMAGE_WIDTH*IMAGE_HEIGHT+1)  per-frame zero-output count (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clk edge): valid_out=0, all data_out=0, last_out=0, frame_done=0, pixel counter=0, zero_cnt=0. ready_out=1 on the first cycle after reset.
- Handshake: accept when valid_in && ready_out. Transfer out when valid_out && ready_in. ready_out = !valid_out || ready_in (combinational). An accept and a transfer out may occur in the same cycle; the register then reloads with no bubble.
- While valid_out=1 and ready_in=0: data_out, last_out and valid_out hold stable.
- Latency: exactly 1 cycle from accept to valid_out=1. Sustained throughput is 1 beat/cycle.
- mode and clip_max are sampled only on accept. Changing them mid-stream affects only later beats.
- Per channel x (signed), the result y is:
  - mode 00: y = x.
  - mode 01: y = x > 0 ? x : 0.
  - mode 10: y = x >= 0 ? x : x >>> LEAK_SHIFT. Rounding is toward minus infinity, e.g. -1 -> -1 and -9 -> -2 at LEAK_SHIFT=3.
  - mode 11: y = x <= 0 ? 0 : (x > clip_max ? clip_max : x). If clip_max <= 0, the output is 0.
  - No width growth; the output is DATA_BITS.
- Pixel counter: counts accepted beats 0..IMAGE_WIDTH*IMAGE_HEIGHT-1.
  - The accepted beat at index W*H-1 sets last_out with that output beat, and the counter wraps to 0.
  - The counter is sized $clog2(W*H) and never exceeds W*H-1.
- frame_done: asserted for the single cycle in which valid_out && ready_in && last_out. Deasserted in every other cycle.
- Reset mid-frame: the partial frame is discarded, the counter returns to 0, and any held output beat is dropped (valid_out=0).

Optional Feature:
Macro RELU_ACT_STATS_EN.
- When defined:
  - An internal accumulator adds the number of channels whose output is exactly 0 in each accepted beat.
  - On accept of the last beat of a frame, zero_cnt is loaded with the frame total including that beat, and the accumulator clears.
  - zero_cnt holds until the next frame end or reset.
- When undefined: the accumulator is not built and zero_cnt is tied to 0.

Test Plan:
1. Reset then mode=01, CHANNELS=4, single beat {5,-3,0,0x7FFFFFFF} -> one cycle later valid_out=1, data_out={5,0,0,0x7FFFFFFF}.
2. mode=10, LEAK_SHIFT=3, beat {-8,-1,-9,16} -> data_out={-1,-1,-2,16}. mode=11, clip_max=10, beat {12,-4,7,10} -> {10,0,7,10}.
3. Back-pressure:
   - Stimulus: stream beats A,B,C with valid_in=1 continuously; hold ready_in=0 for 3 cycles after A appears.
   - Required: data_out stays A and ready_out=0 while ready_in=0; then A, B, C each appear exactly once, in order, with no loss or duplication.
4. W=3, H=2 (6 beats), ready_in=1:
   - last_out=1 only on beat 6, and frame_done pulses exactly once, in the cycle beat 6 transfers out.
   - A 7th beat is index 0 of the next frame with last_out=0.
5. Assert rst after 3 of 6 beats of a frame, then send 6 beats -> last_out is on the 6th post-reset beat, not the 3rd.
6. With RELU_ACT_STATS_EN, mode=01, W=H=1, CHANNELS=4, beat {-1,0,2,-5} -> zero_cnt=3 after the frame. Without the macro -> zero_cnt stays 0.

Source files
------------

// File: rtl/relu_act_pipe_if.sv
// relu_act_pipe_if: pixel stream bundle for the activation stage.
// Holds the upstream (valid_in/ready_out/data_in) and downstream
// (valid_out/ready_in/data_out/last_out) handshakes of one block.
// The slave modport is the block's view; the master modport is the
// view of whatever drives and consumes the stream around it.
interface relu_act_pipe_if #(
   parameter int CHANNELS  = 64,
   parameter int DATA_BITS = 32
);

   logic                                 valid_in;
   logic                                 ready_out;
   logic [0:CHANNELS-1][DATA_BITS-1:0]   data_in;
   logic                                 valid_out;
   logic                                 ready_in;
   logic [0:CHANNELS-1][DATA_BITS-1:0]   data_out;
   logic                                 last_out;

   modport slave (
      input  valid_in, data_in, ready_in,
      output ready_out, valid_out, data_out, last_out
   );

   modport master (
      output valid_in, data_in, ready_in,
      input  ready_out, valid_out, data_out, last_out
   );

endinterface

// File: rtl/relu_act_pipe.sv
// relu_act_pipe: multi-channel activation stage with one registered
// pipeline slot, valid/ready back-pressure and frame tracking.
// Modes: 00 bypass, 01 ReLU, 10 leaky ReLU (x >>> LEAK_SHIFT for x < 0),
// 11 clipped ReLU clamped to [0, clip_max].
// Optional feature macro: RELU_ACT_STATS_EN (per-frame zero-output count
// on zero_cnt; tied to 0 when the macro is undefined).
module relu_act_pipe #(
   parameter int CHANNELS     = 64,
   parameter int DATA_BITS    = 32,
   parameter int IMAGE_WIDTH  = 13,
   parameter int IMAGE_HEIGHT = 17,
   parameter int LEAK_SHIFT   = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           mode,
   input  logic [DATA_BITS-1:0] clip_max,
   relu_act_pipe_if.slave       bus,
   output logic                 frame_done,
   output logic [$clog2(CHANNELS*IMAGE_WIDTH*IMAGE_HEIGHT+1)-1:0] zero_cnt
);

   localparam int PIXELS   = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int PIX_BITS = (PIXELS > 1) ? $clog2(PIXELS) : 1;
   localparam int ZW       = $clog2(CHANNELS * PIXELS + 1);

   localparam logic [1:0] MODE_BYPASS = 2'b00;
   localparam logic [1:0] MODE_RELU   = 2'b01;
   localparam logic [1:0] MODE_LEAKY  = 2'b10;
   localparam logic [1:0] MODE_CLIP   = 2'b11;

   logic                               accept;
   logic                               xfer;
   logic                               is_last;
   logic [PIX_BITS-1:0]                pix_cnt;
   logic [0:CHANNELS-1][DATA_BITS-1:0] act_data;

   // Handshake: the output slot can take a new beat when empty or draining.
   assign bus.ready_out = !bus.valid_out || bus.ready_in;
   assign accept        = bus.valid_in && bus.ready_out;
   assign xfer          = bus.valid_out && bus.ready_in;
   assign is_last       = (pix_cnt == PIX_BITS'(PIXELS - 1));
   assign frame_done    = xfer && bus.last_out;

   // Per-channel activation of the incoming beat with the current mode.
   always_comb begin : act_comb
      logic signed [DATA_BITS-1:0] x;
      logic signed [DATA_BITS-1:0] shifted;
      logic                        x_pos;
      logic                        clip_pos;
      // NOTE: every variable gets a value before any branch so no latch is
      // inferred; blocking assignments are used because this is pure
      // combinational logic evaluated top to bottom.
      act_data = '0;
      x        = '0;
      shifted  = '0;
      x_pos    = 1'b0;
      clip_pos = !clip_max[DATA_BITS-1] && (clip_max != '0);
      for (int c = 0; c < CHANNELS; c++) begin
         x       = bus.data_in[c];
         shifted = x >>> LEAK_SHIFT;
         x_pos   = !x[DATA_BITS-1] && (x != '0);
         case (mode)
            MODE_BYPASS: act_data[c] = x;
            MODE_RELU:   act_data[c] = x_pos ? x : '0;
            MODE_LEAKY:  act_data[c] = x[DATA_BITS-1] ? shifted : x;
            MODE_CLIP: begin
               // Both operands are known positive here, so the magnitude
               // compare is safe on the raw bit patterns.
               if (x_pos && clip_pos)
                  act_data[c] = (bus.data_in[c] > clip_max) ? clip_max : x;
               else
                  act_data[c] = '0;
            end
            default:     act_data[c] = x;
         endcase
      end
   end

   // Output register, frame position counter and last-pixel flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the data register is reset as well so data_out reads as
         // zero after reset, not just invalid.
         bus.valid_out <= 1'b0;
         bus.data_out  <= '0;
         bus.last_out  <= 1'b0;
         pix_cnt       <= '0;
      end else if (accept) begin
         bus.valid_out <= 1'b1;
         bus.data_out  <= act_data;
         bus.last_out  <= is_last;
         pix_cnt       <= is_last ? '0 : pix_cnt + PIX_BITS'(1);
      end else if (xfer) begin
         bus.valid_out <= 1'b0;
         bus.last_out  <= 1'b0;
      end
   end

`ifdef RELU_ACT_STATS_EN
   logic [ZW-1:0] zero_beat;
   logic [ZW-1:0] zero_acc;

   // Number of channels of the incoming beat whose activated value is zero.
   always_comb begin
      zero_beat = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (act_data[c] == '0)
            zero_beat = zero_beat + ZW'(1);
      end
   end

   // Accumulate zeros over a frame and publish the total on the last beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_acc <= '0;
         zero_cnt <= '0;
      end else if (accept) begin
         if (is_last) begin
            zero_cnt <= zero_acc + zero_beat;
            zero_acc <= '0;
         end else begin
            zero_acc <= zero_acc + zero_beat;
         end
      end
   end
`else
   assign zero_cnt = '0;
`endif

endmodule

// File: tb/tb_relu_act_pipe.sv
// tb_relu_act_pipe: directed and randomized checks of relu_act_pipe
// against a queue-based reference model built from the activation rules.
module tb_relu_act_pipe;

   localparam int CH = 4;
   localparam int DB = 32;
   localparam int W  = 3;
   localparam int H  = 2;
   localparam int LS = 3;
   localparam int ZW = $clog2(CH * W * H + 1);
`ifdef RELU_ACT_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef logic [0:CH-1][DB-1:0] beat_t;
   typedef struct { logic [1:0] mode; logic [DB-1:0] clip; beat_t data; } src_t;
   typedef struct { beat_t data; logic last; } out_t;

   logic          clk;
   logic          rst;
   logic [1:0]    mode;
   logic [DB-1:0] clip_max;
   logic          frame_done;
   logic [ZW-1:0] zero_cnt;

   relu_act_pipe_if #(.CHANNELS(CH), .DATA_BITS(DB)) bus ();

   relu_act_pipe #(
      .CHANNELS(CH), .DATA_BITS(DB), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
      .LEAK_SHIFT(LS)
   ) dut (
      .clk(clk), .rst(rst), .mode(mode), .clip_max(clip_max), .bus(bus.slave),
      .frame_done(frame_done), .zero_cnt(zero_cnt)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   src_t src[$];
   out_t exp_q[$];
   out_t out_log[$];
   int   pix;
   int   zero_acc;
   int   exp_zero;
   int   done_seen;
   logic in_gap;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic beat_t mk(input int a, input int b, input int c, input int d);
      beat_t r;
      r[0] = a; r[1] = b; r[2] = c; r[3] = d;
      return r;
   endfunction

   // Reference activation, computed in wide signed arithmetic.
   function automatic logic [DB-1:0] ref_act(input logic [1:0] m, input logic [DB-1:0] clip,
                                             input logic [DB-1:0] xin);
      longint x, c, y, d;
      x = $signed(xin);
      c = $signed(clip);
      d = longint'(1) << LS;
      case (m)
         2'd0:    y = x;
         2'd1:    y = (x > 0) ? x : 0;
         2'd2:    y = (x >= 0) ? x : (x - (d - 1)) / d;   // floor division
         default: y = (x <= 0 || c <= 0) ? 0 : ((x > c) ? c : x);
      endcase
      return y[DB-1:0];
   endfunction

   task automatic clear_model();
      exp_q.delete();
      pix      = 0;
      zero_acc = 0;
      exp_zero = 0;
   endtask

   // One clock cycle: drive at negedge, compare, advance the model, clock.
   task automatic step(input logic rdy);
      logic acc, xfer;
      out_t e;
      int   z;
      bus.ready_in = rdy;
      bus.valid_in = (src.size() > 0) && !in_gap;
      if (bus.valid_in) begin
         mode = src[0].mode; clip_max = src[0].clip; bus.data_in = src[0].data;
      end else begin
         mode = 2'($urandom); clip_max = $urandom;
         bus.data_in = {$urandom, $urandom, $urandom, $urandom};
      end
      #1;
      chk("valid_out", bus.valid_out, exp_q.size() != 0);
      chk("ready_out", bus.ready_out, exp_q.size() == 0 || rdy);
      chk("frame_done", frame_done, exp_q.size() != 0 && rdy && exp_q[0].last);
      chk("zero_cnt", zero_cnt, exp_zero);
      if (exp_q.size() != 0) begin
         chk("data_out", bus.data_out, exp_q[0].data);
         chk("last_out", bus.last_out, exp_q[0].last);
      end
      if (frame_done) done_seen++;
      acc  = bus.valid_in && (exp_q.size() == 0 || rdy);
      xfer = (exp_q.size() != 0) && rdy;
      if (xfer) begin
         void'(exp_q.pop_front());
         e.data = bus.data_out; e.last = bus.last_out;
         out_log.push_back(e);
      end
      if (acc) begin
         z = 0;
         for (int c = 0; c < CH; c++) begin
            e.data[c] = ref_act(src[0].mode, src[0].clip, src[0].data[c]);
            if (e.data[c] == '0) z++;
         end
         e.last = (pix == W * H - 1);
         exp_q.push_back(e);
         pix = (pix + 1) % (W * H);
         if (STATS) begin
            zero_acc += z;
            if (e.last) begin
               exp_zero = zero_acc;
               zero_acc = 0;
            end
         end
         void'(src.pop_front());
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      bus.valid_in = 1'b0;
      bus.ready_in = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_model();
      #1;
      chk("rst_valid_out", bus.valid_out, 1'b0);
      chk("rst_data_out", bus.data_out, '0);
      chk("rst_last_out", bus.last_out, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_ready_out", bus.ready_out, 1'b1);
      chk("rst_zero_cnt", zero_cnt, '0);
   endtask

   task automatic push(input logic [1:0] m, input logic [DB-1:0] c, input beat_t d);
      src_t s;
      s.mode = m; s.clip = c; s.data = d;
      src.push_back(s);
   endtask

   function automatic beat_t rnd_beat();
      beat_t r;
      for (int c = 0; c < CH; c++) begin
         case ($urandom_range(0, 3))
            0:       r[c] = $urandom;
            1:       r[c] = 32'($urandom_range(0, 40)) - 32'd20;
            2:       r[c] = '0;
            default: r[c] = 32'($urandom_range(0, 2000)) - 32'd1000;
         endcase
      end
      return r;
   endfunction

   initial begin
      int n0, d0;
      beat_t a, b, c;
      clk = 1'b0; rst = 1'b1; mode = '0; clip_max = '0; in_gap = 1'b0;
      bus.valid_in = 1'b0; bus.ready_in = 1'b0; bus.data_in = '0;
      done_seen = 0;
      clear_model();
      @(negedge clk);
      do_reset();

      // ReLU on one beat, then leaky and clipped ReLU.
      push(2'b01, '0, mk(5, -3, 0, 32'h7FFF_FFFF));
      step(1); step(1);
      chk("t1_relu", out_log[$].data, mk(5, 0, 0, 32'h7FFF_FFFF));
      push(2'b10, '0, mk(-8, -1, -9, 16));
      push(2'b11, 32'd10, mk(12, -4, 7, 10));
      step(1); step(1); step(1);
      chk("t2_leaky", out_log[$-1].data, mk(-1, -1, -2, 16));
      chk("t2_clip", out_log[$].data, mk(10, 0, 7, 10));
      push(2'b11, 32'hFFFF_FFFB, mk(3, 100, -2, 0));
      step(1); step(1);
      chk("t2_clip_neg", out_log[$].data, mk(0, 0, 0, 0));

      // Back-pressure: A held for three stalled cycles, then A, B, C in order.
      do_reset();
      a = rnd_beat(); b = rnd_beat(); c = rnd_beat();
      push(2'b00, '0, a); push(2'b00, '0, b); push(2'b00, '0, c);
      n0 = out_log.size();
      step(1);
      step(0); step(0); step(0);
      for (int i = 0; i < 10 && (src.size() > 0 || exp_q.size() > 0); i++) step(1);
      chk("t3_count", out_log.size() - n0, 3);
      chk("t3_a", out_log[n0].data, a);
      chk("t3_b", out_log[n0+1].data, b);
      chk("t3_c", out_log[n0+2].data, c);

      // Frame tracking over W*H = 6 beats plus one beat of the next frame.
      do_reset();
      n0 = out_log.size(); d0 = done_seen;
      for (int i = 0; i < 7; i++) push(2'b00, '0, rnd_beat());
      for (int i = 0; i < 9; i++) step(1);
      chk("t4_count", out_log.size() - n0, 7);
      for (int i = 0; i < 7; i++) chk("t4_last", out_log[n0+i].last, i == 5);
      chk("t4_done_pulses", done_seen - d0, 1);

      // Reset mid-frame: counting restarts from the first post-reset beat.
      do_reset();
      for (int i = 0; i < 3; i++) push(2'b01, '0, rnd_beat());
      step(1); step(1); step(1);
      src.delete();
      do_reset();
      n0 = out_log.size();
      for (int i = 0; i < 6; i++) push(2'b01, '0, rnd_beat());
      for (int i = 0; i < 8; i++) step(1);
      chk("t5_count", out_log.size() - n0, 6);
      chk("t5_third_not_last", out_log[n0+2].last, 1'b0);
      chk("t5_sixth_last", out_log[n0+5].last, 1'b1);

      // Zero statistics over one frame: three zero channels per beat.
      do_reset();
      for (int i = 0; i < 6; i++) push(2'b01, '0, mk(-1, 0, 2, -5));
      for (int i = 0; i < 8; i++) step(1);
      chk("t6_zero_cnt", zero_cnt, STATS ? 18 : 0);

      // Randomized traffic with random stalls on both sides.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 4) == 0)
            push(2'b11, 32'($urandom_range(0, 60)) - 32'd10, rnd_beat());
         else
            push(2'($urandom), $urandom, rnd_beat());
      end
      for (int i = 0; i < 3000 && (src.size() > 0 || exp_q.size() > 0); i++) begin
         in_gap = ($urandom_range(0, 3) == 0);
         step($urandom_range(0, 3) != 0);
      end
      in_gap = 1'b0;
      chk("rand_src_drained", src.size(), 0);
      chk("rand_out_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
